// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty flags, fill level,
// overflow/underflow pulses and a choice of registered or first-word-fall-through read.
module sync_fifo_prog #(
    parameter  int WIDTH     = 8,
    parameter  int DEPTH     = 16,
    parameter  int FWFT      = 0,
    parameter  int AF_THRESH = 14,
    parameter  int AE_THRESH = 2,
    localparam int LW        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             winc,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rinc,
    output logic [WIDTH-1:0] rdata,
    output logic             wfull,
    output logic             rempty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [LW-1:0]    level,
    output logic             overflow,
    output logic             underflow
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [LW-1:0]    level_nxt;
    logic             wr_en;
    logic             rd_en;

    // DEPTH need not be a power of two, so wrap on an explicit compare.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign wr_en = winc & ~wfull;
    assign rd_en = rinc & ~rempty;

    always_comb begin
        level_nxt = level;
        if (wr_en && !rd_en) begin
            level_nxt = level + LW'(1);
        end else if (rd_en && !wr_en) begin
            level_nxt = level - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr] <= wdata;
        end
    end

    // Flags come from the next-state level so they are exact the cycle after each edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr         <= '0;
            rptr         <= '0;
            level        <= '0;
            wfull        <= 1'b0;
            rempty       <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_en) begin
                wptr <= ptr_inc(wptr);
            end
            if (rd_en) begin
                rptr <= ptr_inc(rptr);
            end
            level        <= level_nxt;
            wfull        <= (level_nxt == LW'(DEPTH));
            rempty       <= (level_nxt == '0);
            almost_full  <= (level_nxt >= LW'(AF_THRESH));
            almost_empty <= (level_nxt <= LW'(AE_THRESH));
            overflow     <= winc & wfull;
            underflow    <= rinc & rempty;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented directly; forced to zero while empty so it never shows stale data.
            assign rdata = rempty ? '0 : mem[rptr];
        end else begin : g_reg_read
            logic [WIDTH-1:0] rdata_q;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    rdata_q <= '0;
                end else if (rd_en) begin
                    rdata_q <= mem[rptr];
                end
            end

            assign rdata = rdata_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: a DEPTH=16 registered-read instance driven from a vector table,
// and a DEPTH=5 FWFT instance driven by wrap sequences and random traffic against a queue model.
module tb_sync_fifo_prog;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    // DEPTH=16, FWFT=0, AF=14, AE=2
    logic       a_winc, a_rinc;
    logic [7:0] a_wdata, a_rdata;
    logic       a_wfull, a_rempty, a_af, a_ae, a_ovf, a_udf;
    logic [4:0] a_level;

    // DEPTH=5, FWFT=1, AF=4, AE=1
    logic       b_winc, b_rinc;
    logic [7:0] b_wdata, b_rdata;
    logic       b_wfull, b_rempty, b_af, b_ae, b_ovf, b_udf;
    logic [2:0] b_level;

    sync_fifo_prog #(.WIDTH(8), .DEPTH(16), .FWFT(0), .AF_THRESH(14), .AE_THRESH(2)) u_d16 (
        .clk(clk), .rstn(rstn), .winc(a_winc), .wdata(a_wdata), .rinc(a_rinc),
        .rdata(a_rdata), .wfull(a_wfull), .rempty(a_rempty), .almost_full(a_af),
        .almost_empty(a_ae), .level(a_level), .overflow(a_ovf), .underflow(a_udf)
    );

    sync_fifo_prog #(.WIDTH(8), .DEPTH(5), .FWFT(1), .AF_THRESH(4), .AE_THRESH(1)) u_d5 (
        .clk(clk), .rstn(rstn), .winc(b_winc), .wdata(b_wdata), .rinc(b_rinc),
        .rdata(b_rdata), .wfull(b_wfull), .rempty(b_rempty), .almost_full(b_af),
        .almost_empty(b_ae), .level(b_level), .overflow(b_ovf), .underflow(b_udf)
    );

    typedef struct {
        logic       winc;
        logic       rinc;
        logic [7:0] wdata;
        int         exp_level;
        logic       exp_ovf;
        logic       exp_udf;
    } vec_t;

    vec_t       vecs[$];
    int         n_cmp = 0;
    int         n_err = 0;

    int         lvl16 = 0;
    logic [7:0] q16[$];
    logic [7:0] rd16 = 8'h00;

    int         lvl5 = 0;
    logic [7:0] q5[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic r, input logic [7:0] d,
                                input int lv, input logic ov, input logic ud);
        vec_t v;
        v.winc = w; v.rinc = r; v.wdata = d;
        v.exp_level = lv; v.exp_ovf = ov; v.exp_udf = ud;
        return v;
    endfunction

    // Registered-read instance: level and error pulses come from the table, data from the queue.
    task automatic step16(input vec_t v);
        logic wr_ok, rd_ok;
        a_winc  = v.winc;
        a_rinc  = v.rinc;
        a_wdata = v.wdata;
        wr_ok = v.winc && (lvl16 < 16);
        rd_ok = v.rinc && (lvl16 > 0);
        if (rd_ok) rd16 = q16.pop_front();
        if (wr_ok) q16.push_back(v.wdata);
        lvl16 = lvl16 + (wr_ok ? 1 : 0) - (rd_ok ? 1 : 0);
        @(posedge clk);
        #1;
        check("d16_level", int'(a_level), v.exp_level);
        check("d16_ovf", int'(a_ovf), int'(v.exp_ovf));
        check("d16_udf", int'(a_udf), int'(v.exp_udf));
        check("d16_wfull", int'(a_wfull), int'(v.exp_level == 16));
        check("d16_rempty", int'(a_rempty), int'(v.exp_level == 0));
        check("d16_afull", int'(a_af), int'(v.exp_level >= 14));
        check("d16_aempty", int'(a_ae), int'(v.exp_level <= 2));
        check("d16_rdata", int'(a_rdata), int'(rd16));
    endtask

    // FWFT instance: everything predicted by the queue model.
    task automatic step5(input logic w, input logic r, input logic [7:0] d);
        logic       wr_ok, rd_ok, ov, ud;
        logic [7:0] tmp;
        b_winc  = w;
        b_rinc  = r;
        b_wdata = d;
        wr_ok = w && (lvl5 < 5);
        rd_ok = r && (lvl5 > 0);
        ov = w && (lvl5 == 5);
        ud = r && (lvl5 == 0);
        if (rd_ok) tmp = q5.pop_front();
        if (wr_ok) q5.push_back(d);
        lvl5 = lvl5 + (wr_ok ? 1 : 0) - (rd_ok ? 1 : 0);
        @(posedge clk);
        #1;
        check("d5_level", int'(b_level), lvl5);
        check("d5_ovf", int'(b_ovf), int'(ov));
        check("d5_udf", int'(b_udf), int'(ud));
        check("d5_wfull", int'(b_wfull), int'(lvl5 == 5));
        check("d5_rempty", int'(b_rempty), int'(lvl5 == 0));
        check("d5_afull", int'(b_af), int'(lvl5 >= 4));
        check("d5_aempty", int'(b_ae), int'(lvl5 <= 1));
        check("d5_head", int'(b_rdata), (lvl5 > 0) ? int'(q5[0]) : 0);
    endtask

    task automatic check_reset_values();
        check("rst_level", int'(a_level), 0);
        check("rst_rempty", int'(a_rempty), 1);
        check("rst_wfull", int'(a_wfull), 0);
        check("rst_aempty", int'(a_ae), 1);
        check("rst_afull", int'(a_af), 0);
        check("rst_rdata", int'(a_rdata), 0);
        check("rst_ovf", int'(a_ovf), 0);
        check("rst_udf", int'(a_udf), 0);
        check("rst5_level", int'(b_level), 0);
        check("rst5_rempty", int'(b_rempty), 1);
        check("rst5_rdata", int'(b_rdata), 0);
    endtask

    initial begin
        logic [7:0] d;

        // 16 writes, full write+read, drain, empty read, empty write+read, final read
        for (int i = 0; i < 16; i++) vecs.push_back(mk(1'b1, 1'b0, 8'(i), i + 1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 8'hEE, 15, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 15, 1'b0, 1'b0));
        for (int i = 0; i < 15; i++) vecs.push_back(mk(1'b0, 1'b1, 8'h00, 14 - i, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 8'h5A, 1, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b0));

        rstn = 1'b0;
        a_winc = 1'b0; a_rinc = 1'b0; a_wdata = 8'h00;
        b_winc = 1'b0; b_rinc = 1'b0; b_wdata = 8'h00;
        #12;
        check_reset_values();
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Traffic, then reset asserted between edges
        step16(mk(1'b1, 1'b0, 8'hA1, 1, 1'b0, 1'b0));
        step16(mk(1'b1, 1'b0, 8'hA2, 2, 1'b0, 1'b0));
        step16(mk(1'b1, 1'b1, 8'hA3, 2, 1'b0, 1'b0));
        step5(1'b1, 1'b0, 8'h77);
        a_winc = 1'b1; a_rinc = 1'b1; a_wdata = 8'hB4;
        #3;
        rstn = 1'b0;
        #1;
        check_reset_values();
        lvl16 = 0; q16.delete(); rd16 = 8'h00;
        lvl5 = 0; q5.delete();
        a_winc = 1'b0; a_rinc = 1'b0; b_winc = 1'b0; b_rinc = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) step16(vecs[i]);
        a_winc = 1'b0; a_rinc = 1'b0;

        // FWFT: write into empty shows the word next cycle, then pop and underflow
        step5(1'b1, 1'b0, 8'hA5);
        check("fwft_a5", int'(b_rdata), 8'hA5);
        check("fwft_not_empty", int'(b_rempty), 0);
        step5(1'b0, 1'b1, 8'h00);
        step5(1'b0, 1'b1, 8'h00);

        // Three rounds of 4 writes, 4 concurrent write+read, 4 reads through a 5-deep ring
        d = 8'h10;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 4; k++) begin step5(1'b1, 1'b0, d); d = d + 8'd1; end
            for (int k = 0; k < 4; k++) begin step5(1'b1, 1'b1, d); d = d + 8'd1; end
            for (int k = 0; k < 4; k++) step5(1'b0, 1'b1, 8'h00);
        end

        // Overfill, full write+read, then random traffic and drain
        for (int k = 0; k < 6; k++) begin step5(1'b1, 1'b0, d); d = d + 8'd1; end
        step5(1'b1, 1'b1, d); d = d + 8'd1;
        for (int k = 0; k < 60; k++) begin
            step5(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), d);
            d = d + 8'd1;
        end
        for (int k = 0; k < 6; k++) step5(1'b0, 1'b1, 8'h00);
        b_winc = 1'b0; b_rinc = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
